oram_backend_block_port: RTL and testbench
==========================================

Name: oram_backend_block_port

Overview:
- Backend-side terminator of the frontend data path.
- Accepts one command per block access. Append/Update consume a block of StoreData chunks into a local block store. Read/ReadRmv stream the stored block back as LoadData chunks.
- Serves as the responder for the frontend's StoreData/LoadData valid/ready streams. Used as the backend in frontend integration and as the small on-chip block store for stash-bypass configurations.

Parameters:
- FEDWidth, 64, chunk width in bits (matches frontend data width).
- BlockChunks, 8, chunks per block (power of two, ≥2).
- NumBlocks, 16, number of addressable blocks (power of two).
- BECMDWidth, 2, command width.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- CmdValid  in  1  command offered
- CmdReady  out  1  command accepted when CmdValid && CmdReady
- Cmd  in  BECMDWidth  BECMD_Update / Append / Read / ReadRmv
- CmdAddr  in  log2(NumBlocks)  block index
- StoreDataReady  out  1  chunk accepted
- StoreDataValid  in  1  chunk offered
- StoreData  in  FEDWidth  store chunk
- LoadDataReady  in  1  consumer ready
- LoadDataValid  out  1  load chunk valid
- LoadData  out  FEDWidth  load chunk
- LoadMiss  out  1  current read targets an invalid block (data is zero)
- CmdError  out  1  one-cycle pulse: Append to a valid block, or Update to an invalid block
- Busy  out  1  not Idle

Behaviour:
- Reset (async, active-high): state=Idle, chunk counter=0, all block valid bits=0, LoadDataValid=0, LoadData=0, LoadMiss=0, CmdError=0, Busy=0, StoreDataReady=0. CmdReady=1 from the first cycle after reset deasserts. RAM contents are not cleared; the valid bits gate them.
- States: Idle, Store, Load.
- Idle:
  - CmdReady=1.
  - On command accept, latch Cmd and CmdAddr and zero the counter.
  - Append/Update → Store. Read/ReadRmv → Load.
  - CmdError pulses in the cycle after accept for Append-to-valid or Update-to-invalid. The operation still proceeds.
- Store:
  - StoreDataReady=1 and CmdReady=0.
  - Each StoreData handshake writes chunk[counter] of block CmdAddr, then counter+1.
  - On the handshake with counter==BlockChunks-1: set valid[CmdAddr], counter wraps to 0, next state Idle. No bubble; a new command can be accepted the next cycle.
- Load:
  - LoadData and LoadDataValid are registered. The first chunk is valid exactly 1 cycle after command accept.
  - LoadData holds stable while LoadDataValid && !LoadDataReady.
  - After each handshake the next chunk is presented the following cycle (full throughput, 1 chunk/cycle).
  - Invalid block: every chunk = 0 and LoadMiss=1 for the whole Load state. The full BlockChunks chunks are still sent.
  - Last-chunk handshake: LoadDataValid=0 next cycle, state Idle, LoadMiss=0. ReadRmv clears valid[CmdAddr] on that same edge.
- Stray traffic: StoreDataValid outside Store is not consumed (Ready=0). LoadDataReady outside Load is ignored. CmdValid while Busy waits.
- Counter: log2(BlockChunks) bits, wraps naturally. Block address and counter concatenate into the RAM address, {CmdAddr, counter}.
- Reset mid-Store: the partially written block stays invalid. Reset mid-Load: LoadDataValid drops asynchronously.

Decomposition:
- Package oram_be_pkg:
  - BECMD_Update=2'd0, BECMD_Append=2'd1, BECMD_Read=2'd2, BECMD_ReadRmv=2'd3
  - state encoding
  - clog2-derived widths
- Sub-module block_chunk_ram:
  - NumBlocks*BlockChunks × FEDWidth
  - one synchronous write port and one combinational read port
  - no reset

Test Plan:
1. Append addr 3 with chunks 0x1000+i (i=0..7), then Read addr 3 with LoadDataReady=1 → LoadDataValid 1 cycle after accept; 8 consecutive chunks 0x1000..0x1007; LoadMiss=0; CmdError never pulses.
2. Read addr 5 after reset → 8 chunks of 0; LoadMiss=1 throughout; state back to Idle after the 8th handshake.
3. Append addr 2 (0xA0+i), ReadRmv addr 2, Read addr 2 → first read returns 0xA0..0xA7; second read returns zeros with LoadMiss=1.
4. Backpressure: during Read toggle LoadDataReady 1,0,0,1,… → LoadData constant while stalled; no chunk skipped or duplicated; exactly 8 handshakes.
5. Update addr 7 (invalid) → CmdError pulses 1 cycle, data stored, valid[7]=1. A second Append addr 7 → CmdError pulses again.
6. Assert Reset after chunk 4 of an Append to addr 1, then Read addr 1 → all outputs 0 during reset; Read returns zeros with LoadMiss=1.

Source files
------------

// File: rtl/oram_be_pkg.sv
// Shared command codes, FSM state encoding and default geometry for the
// backend block port.
package oram_be_pkg;

  localparam int FED_WIDTH_DEF    = 64;
  localparam int BLOCK_CHUNKS_DEF = 8;
  localparam int NUM_BLOCKS_DEF   = 16;
  localparam int BECMD_WIDTH      = 2;

  // Derived index widths for the default geometry.
  localparam int CHUNK_IDX_W = $clog2(BLOCK_CHUNKS_DEF);
  localparam int BLOCK_IDX_W = $clog2(NUM_BLOCKS_DEF);

  typedef enum logic [BECMD_WIDTH-1:0] {
    BECMD_Update  = 2'd0,
    BECMD_Append  = 2'd1,
    BECMD_Read    = 2'd2,
    BECMD_ReadRmv = 2'd3
  } becmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // True for the two commands that stream a block out.
  function automatic logic is_read_cmd(logic [BECMD_WIDTH-1:0] c);
    return (c == BECMD_Read) || (c == BECMD_ReadRmv);
  endfunction

endpackage

// File: rtl/block_chunk_ram.sv
// Flat chunk storage: one synchronous write port, one combinational read
// port. Contents are never reset; block valid bits live in the top.
module block_chunk_ram #(
  parameter int Width = 64,
  parameter int Depth = 128,
  parameter int AddrW = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Write one chunk per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/oram_backend_block_port.sv
// Backend terminator for the frontend StoreData/LoadData streams: stores
// whole blocks on Append/Update and streams them back on Read/ReadRmv.
module oram_backend_block_port
  import oram_be_pkg::*;
#(
  parameter int FEDWidth    = FED_WIDTH_DEF,
  parameter int BlockChunks = BLOCK_CHUNKS_DEF,
  parameter int NumBlocks   = NUM_BLOCKS_DEF,
  parameter int BECMDWidth  = BECMD_WIDTH
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         CmdValid,
  output logic                         CmdReady,
  input  logic [BECMDWidth-1:0]        Cmd,
  input  logic [$clog2(NumBlocks)-1:0] CmdAddr,
  output logic                         StoreDataReady,
  input  logic                         StoreDataValid,
  input  logic [FEDWidth-1:0]          StoreData,
  input  logic                         LoadDataReady,
  output logic                         LoadDataValid,
  output logic [FEDWidth-1:0]          LoadData,
  output logic                         LoadMiss,
  output logic                         CmdError,
  output logic                         Busy
);

  localparam int CW = $clog2(BlockChunks);
  localparam int AW = $clog2(NumBlocks);
  localparam logic [CW-1:0] LAST = CW'(BlockChunks - 1);

  state_e                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_inc;
  logic [AW-1:0]         addr_q;
  logic [BECMDWidth-1:0] cmd_q;
  logic [NumBlocks-1:0]  blk_valid;
  logic                  cmd_acc, st_hs, ld_hs;
  logic [AW+CW-1:0]      rd_addr;
  logic [FEDWidth-1:0]   rd_data;

  assign cnt_inc = cnt + 1'b1;
  assign cmd_acc = CmdValid && CmdReady;
  assign st_hs   = StoreDataReady && StoreDataValid;
  assign ld_hs   = (state == ST_LOAD) && LoadDataValid && LoadDataReady;
  assign Busy    = (state != ST_IDLE);

  // Idle reads chunk 0 of the addressed block so it can be registered on
  // accept; during Load we prefetch the chunk after the one being shown.
  assign rd_addr = (state == ST_LOAD) ? {addr_q, cnt_inc} : {CmdAddr, {CW{1'b0}}};

  block_chunk_ram #(
    .Width (FEDWidth),
    .Depth (NumBlocks * BlockChunks),
    .AddrW (AW + CW)
  ) u_ram (
    .clk   (Clock),
    .we    (st_hs),
    .waddr ({addr_q, cnt}),
    .wdata (StoreData),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake readies.
  always_comb begin
    state_nxt      = state;
    CmdReady       = 1'b0;
    StoreDataReady = 1'b0;
    case (state)
      ST_IDLE: begin
        CmdReady = !Reset;
        if (CmdValid && !Reset)
          state_nxt = is_read_cmd(Cmd) ? ST_LOAD : ST_STORE;
      end
      ST_STORE: begin
        StoreDataReady = 1'b1;
        if (StoreDataValid && cnt == LAST) state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (LoadDataValid && LoadDataReady && cnt == LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, chunk counter, block valid bits and registered load port.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt           <= '0;
      addr_q        <= '0;
      cmd_q         <= '0;
      blk_valid     <= '0;
      LoadDataValid <= 1'b0;
      LoadData      <= '0;
      LoadMiss      <= 1'b0;
      CmdError      <= 1'b0;
    end else begin
      // Misuse is flagged but the operation still runs.
      CmdError <= cmd_acc &&
                  (((Cmd == BECMD_Append) &&  blk_valid[CmdAddr]) ||
                   ((Cmd == BECMD_Update) && !blk_valid[CmdAddr]));
      if (cmd_acc) begin
        addr_q <= CmdAddr;
        cmd_q  <= Cmd;
        cnt    <= '0;
        if (is_read_cmd(Cmd)) begin
          LoadDataValid <= 1'b1;
          LoadMiss      <= !blk_valid[CmdAddr];
          LoadData      <= blk_valid[CmdAddr] ? rd_data : '0;
        end
      end
      if (st_hs) begin
        cnt <= cnt_inc;
        if (cnt == LAST) blk_valid[addr_q] <= 1'b1;
      end
      if (ld_hs) begin
        if (cnt == LAST) begin
          cnt           <= '0;
          LoadDataValid <= 1'b0;
          LoadMiss      <= 1'b0;
          LoadData      <= '0;
          if (cmd_q == BECMD_ReadRmv) blk_valid[addr_q] <= 1'b0;
        end else begin
          cnt      <= cnt_inc;
          LoadData <= LoadMiss ? '0 : rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_oram_backend_block_port.sv
// Self-checking bench: directed vector table, reset corner cases, then
// random commands checked against a per-block reference model.
module tb_oram_backend_block_port;
  import oram_be_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [1:0]  Cmd = 2'd0;
  logic [3:0]  CmdAddr = 4'd0;
  logic        StoreDataReady;
  logic        StoreDataValid = 1'b0;
  logic [63:0] StoreData = 64'd0;
  logic        LoadDataReady = 1'b0;
  logic        LoadDataValid;
  logic [63:0] LoadData;
  logic        LoadMiss;
  logic        CmdError;
  logic        Busy;

  oram_backend_block_port dut (
    .Clock(Clock), .Reset(Reset),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .Cmd(Cmd), .CmdAddr(CmdAddr),
    .StoreDataReady(StoreDataReady), .StoreDataValid(StoreDataValid), .StoreData(StoreData),
    .LoadDataReady(LoadDataReady), .LoadDataValid(LoadDataValid), .LoadData(LoadData),
    .LoadMiss(LoadMiss), .CmdError(CmdError), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: a block is "base + chunk index" when valid, else zeros.
  logic [63:0] blk_base [16];
  bit          vld_m    [16];

  typedef struct {
    logic [1:0]  cmd;
    int          addr;
    logic [63:0] base;   // store data base, or expected read data base
    int          mode;   // 0 full rate, 1 ready 1,0,0 pattern, 2 random
    bit          err;
    bit          miss;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Issues one command from a negedge and runs its whole data phase.
  task automatic run_op(input logic [1:0] c, input int a, input logic [63:0] base,
                        input int mode, input bit exp_err, input bit exp_miss);
    int t;
    int k;
    bit r;
    t = 0;
    while (!CmdReady && t < 20) begin @(negedge Clock); t++; end
    chk("cmd_ready_wait", 64'(CmdReady), 64'd1);
    CmdValid = 1'b1; Cmd = c; CmdAddr = 4'(a);
    @(posedge Clock); @(negedge Clock);
    CmdValid = 1'b0;
    chk("cmd_error", 64'(CmdError), 64'(exp_err));
    chk("busy", 64'(Busy), 64'd1);
    chk("cmd_ready_busy", 64'(CmdReady), 64'd0);
    k = 0; t = 0;
    if (c == BECMD_Update || c == BECMD_Append) begin
      while (k < 8 && t < 200) begin
        chk("store_ready", 64'(StoreDataReady), 64'd1);
        r = (mode == 0) || ($urandom_range(3) != 0);
        StoreDataValid = r; StoreData = base + 64'(k);
        @(posedge Clock); @(negedge Clock);
        if (r) k++;
        t++;
        chk("cmd_error_once", 64'(CmdError), 64'd0);
      end
      StoreDataValid = 1'b0;
      chk("store_count", 64'(k), 64'd8);
      chk("store_done_idle", 64'(Busy), 64'd0);
      blk_base[a] = base; vld_m[a] = 1'b1;
    end else begin
      while (k < 8 && t < 200) begin
        chk("load_valid", 64'(LoadDataValid), 64'd1);
        chk("load_data", LoadData, exp_miss ? 64'd0 : base + 64'(k));
        chk("load_miss", 64'(LoadMiss), 64'(exp_miss));
        r = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 3 == 0) : 1'($urandom_range(1));
        LoadDataReady = r;
        @(posedge Clock); @(negedge Clock);
        if (r) k++;
        t++;
      end
      LoadDataReady = 1'b0;
      chk("load_count", 64'(k), 64'd8);
      chk("load_end_valid", 64'(LoadDataValid), 64'd0);
      chk("load_end_miss", 64'(LoadMiss), 64'd0);
      chk("load_end_busy", 64'(Busy), 64'd0);
      if (c == BECMD_ReadRmv) vld_m[a] = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ldvalid"}, 64'(LoadDataValid), 64'd0);
    chk({tag, "_lddata"}, LoadData, 64'd0);
    chk({tag, "_miss"}, 64'(LoadMiss), 64'd0);
    chk({tag, "_cmderr"}, 64'(CmdError), 64'd0);
    chk({tag, "_busy"}, 64'(Busy), 64'd0);
    chk({tag, "_stready"}, 64'(StoreDataReady), 64'd0);
    chk({tag, "_cmdready"}, 64'(CmdReady), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{BECMD_Append,  3, 64'h1000,    0, 1'b0, 1'b0};
    vecs[1]  = '{BECMD_Read,    3, 64'h1000,    0, 1'b0, 1'b0};
    vecs[2]  = '{BECMD_Read,    5, 64'h0,       0, 1'b0, 1'b1};
    vecs[3]  = '{BECMD_Append,  2, 64'hA0,      0, 1'b0, 1'b0};
    vecs[4]  = '{BECMD_ReadRmv, 2, 64'hA0,      0, 1'b0, 1'b0};
    vecs[5]  = '{BECMD_Read,    2, 64'h0,       0, 1'b0, 1'b1};
    vecs[6]  = '{BECMD_Read,    3, 64'h1000,    1, 1'b0, 1'b0};
    vecs[7]  = '{BECMD_Update,  7, 64'h700,     2, 1'b1, 1'b0};
    vecs[8]  = '{BECMD_Read,    7, 64'h700,     1, 1'b0, 1'b0};
    vecs[9]  = '{BECMD_Append,  7, 64'h7700,    0, 1'b1, 1'b0};
    vecs[10] = '{BECMD_Read,    7, 64'h7700,    2, 1'b0, 1'b0};
    vecs[11] = '{BECMD_Update,  3, 64'h3000,    2, 1'b0, 1'b0};
    vecs[12] = '{BECMD_Read,    3, 64'h3000,    2, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin blk_base[i] = '0; vld_m[i] = 1'b0; end

    // Reset state.
    repeat (2) @(negedge Clock);
    check_reset_outputs("reset");
    Reset = 1'b0;
    @(negedge Clock);
    chk("post_reset_cmdready", 64'(CmdReady), 64'd1);

    // Stray stream traffic in Idle is neither consumed nor answered.
    StoreDataValid = 1'b1; LoadDataReady = 1'b1;
    #1 chk("stray_stready", 64'(StoreDataReady), 64'd0);
    @(posedge Clock); @(negedge Clock);
    chk("stray_ldvalid", 64'(LoadDataValid), 64'd0);
    chk("stray_busy", 64'(Busy), 64'd0);
    StoreDataValid = 1'b0; LoadDataReady = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 13; i++)
      run_op(vecs[i].cmd, vecs[i].addr, vecs[i].base, vecs[i].mode, vecs[i].err, vecs[i].miss);

    // Reset in the middle of a Load: valid must drop without a clock edge.
    CmdValid = 1'b1; Cmd = BECMD_Read; CmdAddr = 4'd3;
    @(posedge Clock); @(negedge Clock);
    CmdValid = 1'b0; LoadDataReady = 1'b1;
    @(posedge Clock); @(negedge Clock);
    LoadDataReady = 1'b0;
    chk("midload_valid", 64'(LoadDataValid), 64'd1);
    Reset = 1'b1;
    #1 check_reset_outputs("midload_rst");
    @(negedge Clock); Reset = 1'b0;
    for (int i = 0; i < 16; i++) vld_m[i] = 1'b0;
    @(negedge Clock);
    run_op(BECMD_Read, 3, 64'h0, 0, 1'b0, 1'b1);

    // Reset after four chunks of an Append: block 1 stays invalid.
    CmdValid = 1'b1; Cmd = BECMD_Append; CmdAddr = 4'd1;
    @(posedge Clock); @(negedge Clock);
    CmdValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      StoreDataValid = 1'b1; StoreData = 64'h5500 + 64'(i);
      @(posedge Clock); @(negedge Clock);
    end
    StoreDataValid = 1'b0;
    Reset = 1'b1;
    #1 check_reset_outputs("midstore_rst");
    @(negedge Clock); Reset = 1'b0;
    @(negedge Clock);
    run_op(BECMD_Read, 1, 64'h0, 0, 1'b0, 1'b1);

    // Random commands against the model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  c;
      int          a;
      logic [63:0] b;
      bit          e;
      c = 2'($urandom_range(3));
      a = $urandom_range(3);
      e = ((c == BECMD_Append) && vld_m[a]) || ((c == BECMD_Update) && !vld_m[a]);
      if (c == BECMD_Update || c == BECMD_Append) b = {$urandom, $urandom};
      else b = blk_base[a];
      run_op(c, a, b, 2, e, !vld_m[a]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
